// File: rtl/rd_sym_eval.sv
// Serial evaluator for N-input totally symmetric (rdNM) functions: popcount CHUNK bits/cycle.
// Optional macro RD_SYM_MASK_EN builds the SYM_MASK output mux; otherwise sym is tied low.
module rd_sym_eval #(
  parameter int          N        = 7,
  parameter int          CHUNK    = 1,
  parameter logic [N:0]  SYM_MASK = 8'b1111_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(N+1)-1:0]   z,
  output logic                     sym
);

  localparam int W   = $clog2(N + 1);
  localparam int P   = (N + CHUNK - 1) / CHUNK;
  localparam int SRW = P * CHUNK;
  localparam int IW  = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t          state;
  logic [SRW-1:0]  sr;
  logic [W-1:0]    acc;
  logic [IW-1:0]   idx;
  logic [W-1:0]    chunk_cnt;
  logic            accept;

  always_comb begin
    chunk_cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_cnt = chunk_cnt + W'(sr[i]);
    end
  end

  // out_ready -> in_ready is the only combinational handshake path.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign z         = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      sr    <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sr    <= SRW'(x);
            acc   <= '0;
            idx   <= '0;
            state <= COUNT;
          end
        end
        COUNT: begin
          acc <= acc + chunk_cnt;
          sr  <= sr >> CHUNK;
          idx <= idx + 1'b1;
          if (idx == IW'(P - 1)) state <= DONE;
        end
        DONE: begin
          // Back-to-back: retire the result and latch the next operand on the same edge.
          if (out_ready) begin
            if (in_valid) begin
              sr    <= SRW'(x);
              acc   <= '0;
              idx   <= '0;
              state <= COUNT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RD_SYM_MASK_EN
  assign sym = SYM_MASK[acc];
`else
  logic unused_sym_mask;
  assign unused_sym_mask = ^SYM_MASK;
  assign sym = 1'b0;
`endif

endmodule
